// File: rtl/string_pkg.sv
// ---------------------------------------------------------------------------
// string_pkg
// Shared constants and types for the string packer and its lane decoder.
//   NBYTES    : characters per packed string word
//   BYTE_W    : bits per character
//   LEN_W     : width of a 0..NBYTES character count
//   NULL_CHAR : string terminator character
//   state_e   : packer FSM states (FILL collects bytes, HOLD offers the word)
// ---------------------------------------------------------------------------
package string_pkg;

  localparam int NBYTES = 8;
  localparam int BYTE_W = 8;
  localparam int LEN_W  = $clog2(NBYTES + 1);

  localparam logic [BYTE_W-1:0] NULL_CHAR = 8'h00;

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_e;

endpackage : string_pkg

// File: rtl/byte_lane_writer.sv
// ---------------------------------------------------------------------------
// byte_lane_writer
// Combinational one-hot lane-enable decode. When en is high, exactly the lane
// selected by idx is enabled; otherwise no lane is enabled.
// Ports:
//   en      : input  write request for this cycle
//   idx     : input  lane index (0 = bits [7:0] of the string word)
//   lane_en : output one-hot lane enables, bit k enables lane k
// ---------------------------------------------------------------------------
module byte_lane_writer #(
  parameter int NBYTES = 8,
  parameter int IDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1
) (
  input  logic              en,
  input  logic [IDX_W-1:0]  idx,
  output logic [NBYTES-1:0] lane_en
);

  always_comb begin
    for (int i = 0; i < NBYTES; i++) begin
      lane_en[i] = en && (idx == IDX_W'(i));
    end
  end

endmodule : byte_lane_writer

// File: rtl/string_packer.sv
// ---------------------------------------------------------------------------
// string_packer
// Packs a valid/ready byte stream LSB-first into an NBYTES-character string
// word and offers the completed word on a valid/ready output port. A string
// ends on a null byte, on in_last, or when the last lane is written. Bytes
// after the terminator are never written, so unused upper lanes read zero.
//
// Optional build macro STRING_PACKER_LEN_EN adds out_len, the count of
// non-null characters in the word, registered alongside out_string.
//
// Ports:
//   clk        : input  rising-edge clock
//   reset_n    : input  asynchronous active-low reset
//   in_valid   : input  in_byte / in_last valid
//   in_ready   : output packer accepts a byte (FILL state)
//   in_byte    : input  character, 8'h00 terminates
//   in_last    : input  force termination after this byte
//   out_valid  : output out_string holds a complete word (HOLD state)
//   out_ready  : input  consumer takes the word
//   out_string : output packed string word, character k in bits [8k+7:8k]
//   out_len    : output non-null character count (STRING_PACKER_LEN_EN only)
// ---------------------------------------------------------------------------
module string_packer
  import string_pkg::*;
#(
  parameter int NBYTES = string_pkg::NBYTES
`ifdef STRING_PACKER_LEN_EN
  ,
  parameter int LEN_W  = string_pkg::LEN_W
`endif
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [BYTE_W-1:0]       in_byte,
  input  logic                    in_last,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [BYTE_W*NBYTES-1:0] out_string
`ifdef STRING_PACKER_LEN_EN
  ,
  output logic [LEN_W-1:0]        out_len
`endif
);

  localparam int IDX_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  state_e                     state_q, state_d;
  logic [IDX_W-1:0]           idx_q, idx_d;
  logic [BYTE_W*NBYTES-1:0]   word_q, word_d;
  logic [NBYTES-1:0]          lane_en;
  logic                       accept;
  logic                       terminate;

  assign in_ready   = (state_q == FILL);
  assign out_valid  = (state_q == HOLD);
  assign out_string = word_q;

  assign accept    = in_valid && in_ready;
  // Null byte, explicit last, and a full word all end the string the same way;
  // null together with in_last is still a single termination.
  assign terminate = (in_byte == NULL_CHAR) || in_last || (idx_q == IDX_W'(NBYTES - 1));

  byte_lane_writer #(
    .NBYTES (NBYTES),
    .IDX_W  (IDX_W)
  ) u_lane_writer (
    .en      (accept),
    .idx     (idx_q),
    .lane_en (lane_en)
  );

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    state_d = state_q;
    idx_d   = idx_q;
    word_d  = word_q;

    unique case (state_q)
      FILL: begin
        for (int i = 0; i < NBYTES; i++) begin
          if (lane_en[i]) word_d[i*BYTE_W +: BYTE_W] = in_byte;
        end
        if (accept) begin
          if (terminate) begin
            state_d = HOLD;
            idx_d   = '0;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
          end
        end
      end
      HOLD: begin
        // Word is held untouched until the consumer takes it, then cleared so
        // the next string starts with all lanes zero.
        if (out_ready) begin
          state_d = FILL;
          word_d  = '0;
        end
      end
      default: begin
        state_d = FILL;
        idx_d   = '0;
        word_d  = '0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update
  // from the same pre-edge values. The word register is reset too: it is a
  // plain register (not a memory) and must read zero right after reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= FILL;
      idx_q   <= '0;
      word_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      word_q  <= word_d;
    end
  end

`ifdef STRING_PACKER_LEN_EN
  logic [LEN_W-1:0] len_q, len_d;

  always_comb begin
    len_d = len_q;
    if (accept && (in_byte != NULL_CHAR)) begin
      // A terminating null is not a character; a non-null in_last byte is.
      len_d = len_q + LEN_W'(1);
    end else if (out_valid && out_ready) begin
      len_d = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) len_q <= '0;
    else          len_q <= len_d;
  end

  assign out_len = len_q;
`endif

endmodule : string_packer

// File: tb/tb_string_packer.sv
// ---------------------------------------------------------------------------
// tb_string_packer
// Directed self-checking bench for string_packer. Inputs change and outputs
// are sampled 1 ns after the rising edge. Build with STRING_PACKER_LEN_EN to
// also check out_len.
// ---------------------------------------------------------------------------
module tb_string_packer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_byte;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_string;
`ifdef STRING_PACKER_LEN_EN
  logic [3:0]  out_len;
`endif

  int total = 0;
  int bad   = 0;

  string_packer dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_byte    (in_byte),
    .in_last    (in_last),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_string (out_string)
`ifdef STRING_PACKER_LEN_EN
    ,
    .out_len    (out_len)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer one byte for exactly one edge; packer must be ready.
  task automatic send_byte(input string tag, input logic [7:0] b, input logic last);
    check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    in_valid = 1'b1;
    in_byte  = b;
    in_last  = last;
    step();
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_byte  = 8'h00;
  endtask

  task automatic check_len(input string tag, input int exp);
`ifdef STRING_PACKER_LEN_EN
    check({tag, "_len"}, 64'(out_len), 64'(exp));
`else
    if (exp < 0) $display("note: negative length expectation in %s", tag);
`endif
  endtask

  // Called right after the terminating edge with out_ready=1: word is valid
  // now and is consumed at the next edge.
  task automatic expect_word(input string tag, input logic [63:0] exp, input int len);
    check({tag, "_valid"}, 64'(out_valid), 64'd1);
    check({tag, "_in_ready_hold"}, 64'(in_ready), 64'd0);
    check({tag, "_string"}, out_string, exp);
    check_len(tag, len);
    step();
    check({tag, "_valid_after"}, 64'(out_valid), 64'd0);
    check({tag, "_string_after"}, out_string, 64'd0);
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    in_byte   = 8'h00;
    in_last   = 1'b0;
    out_ready = 1'b1;
    #2;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_string", out_string, 64'd0);
    check_len("rst", 0);
    #10 reset_n = 1'b1;
    step();

    // AA,BB,CC,00
    send_byte("t1a", 8'hAA, 1'b0);
    check("t1_no_early_valid", 64'(out_valid), 64'd0);
    send_byte("t1b", 8'hBB, 1'b0);
    send_byte("t1c", 8'hCC, 1'b0);
    send_byte("t1d", 8'h00, 1'b0);
    expect_word("t1", 64'h0000000000CCBBAA, 3);

    // Full word 11..88, no null
    for (int i = 1; i <= 8; i++) send_byte("t2", 8'(i * 8'h11), 1'b0);
    expect_word("t2", 64'h8877665544332211, 8);

    // Lone null, then single in_last byte
    send_byte("t3a", 8'h00, 1'b0);
    expect_word("t3a", 64'h0, 0);
    send_byte("t3b", 8'h5A, 1'b1);
    expect_word("t3b", 64'h5A, 1);

    // Null together with in_last: same as null alone
    send_byte("t3c", 8'h42, 1'b0);
    send_byte("t3d", 8'h00, 1'b1);
    expect_word("t3d", 64'h42, 1);

    // Back-pressure in HOLD with a byte offered
    out_ready = 1'b0;
    send_byte("t4a", 8'h01, 1'b0);
    send_byte("t4b", 8'h00, 1'b0);
    in_valid = 1'b1;
    in_byte  = 8'h77;
    in_last  = 1'b1;
    for (int i = 0; i < 10; i++) begin
      check("t4_hold_valid", 64'(out_valid), 64'd1);
      check("t4_hold_string", out_string, 64'h01);
      check("t4_hold_in_ready", 64'(in_ready), 64'd0);
      step();
    end
    out_ready = 1'b1;
    step();
    check("t4_released_valid", 64'(out_valid), 64'd0);
    check("t4_released_in_ready", 64'(in_ready), 64'd1);
    step();
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_byte  = 8'h00;
    expect_word("t4c", 64'h77, 1);

    // Gaps between bytes
    send_byte("t5a", 8'hAA, 1'b0);
    for (int i = 0; i < 3; i++) begin
      check("t5_gap_valid", 64'(out_valid), 64'd0);
      step();
    end
    send_byte("t5b", 8'hBB, 1'b0);
    step();
    step();
    send_byte("t5c", 8'h00, 1'b0);
    expect_word("t5", 64'h000000000000BBAA, 2);

    // Reset mid-FILL
    send_byte("t6a", 8'hAA, 1'b0);
    send_byte("t6b", 8'hBB, 1'b0);
    #2 reset_n = 1'b0;
    #1;
    check("t6_rst_string", out_string, 64'd0);
    check("t6_rst_valid", 64'(out_valid), 64'd0);
    check("t6_rst_in_ready", 64'(in_ready), 64'd1);
    check_len("t6_rst", 0);
    #2 reset_n = 1'b1;
    step();
    send_byte("t6c", 8'hCC, 1'b0);
    send_byte("t6d", 8'h00, 1'b0);
    expect_word("t6", 64'h00000000000000CC, 1);

    // Reset mid-HOLD discards the pending word
    out_ready = 1'b0;
    send_byte("t7a", 8'h33, 1'b1);
    check("t7_pending_valid", 64'(out_valid), 64'd1);
    #2 reset_n = 1'b0;
    #1;
    check("t7_rst_valid", 64'(out_valid), 64'd0);
    check("t7_rst_string", out_string, 64'd0);
    check("t7_rst_in_ready", 64'(in_ready), 64'd1);
    #2 reset_n = 1'b1;
    out_ready = 1'b1;
    step();
    check("t7_after_valid", 64'(out_valid), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_string_packer
